inv_sub_bytes: RTL and testbench
================================

INV_SUB_BYTES -- requirements
Module: inv_sub_bytes

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide port: rst  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-003 SHALL provide port: in_valid  input  1  upstream presents a 128-bit AES state on in_data.
REQ-004 SHALL provide port: in_ready  output  1  block can accept a state this cycle.
REQ-005 SHALL provide port: in_data  input  128  state; byte 0 = in_data[127:120], byte 15 = in_data[7:0].
REQ-006 SHALL provide port: out_valid  output  1  out_data holds a completed InvSubBytes result.
REQ-007 SHALL provide port: out_ready  input  1  downstream accepts out_data this cycle.
REQ-008 SHALL provide port: out_data  output  128  InvSubBytes(in_data), same byte ordering as in_data.
REQ-009 SHALL provide port: busy  output  1  high while the FSM is in BUSY.

Function
REQ-010 SHALL map each byte b to InvSbox(b), the exact inverse of the AES forward S-box: InvSbox(Sbox(x)) = x for all 256 x.
REQ-011 SHALL implement an FSM with three states: IDLE, BUSY, DONE.
REQ-012 SHALL assert in_ready only in IDLE; out_valid only in DONE; busy only in BUSY.
REQ-013 SHALL treat in_valid & in_ready on a rising edge as an accept: capture in_data, clear the byte counter, go IDLE->BUSY.
REQ-014 SHALL ignore in_data and in_valid outside IDLE; no accept is possible in BUSY or DONE.
REQ-015 SHALL, in BUSY, convert N bytes per cycle in ascending byte order (byte 0 first), with N=1 by default (see Configuration).
REQ-016 SHALL use a 4-bit byte counter that advances by N per BUSY cycle, and go BUSY->DONE on the edge that converts byte 15.
REQ-017 SHALL give a latency of 16/N edges from the accept edge to out_valid high: 16 edges by default, 4 edges in PAR4 mode.
REQ-018 SHALL hold out_data stable and out_valid high in DONE until out_valid & out_ready, then go DONE->IDLE with in_ready high on the following cycle.
REQ-019 SHALL not combinationally depend on out_ready for in_ready; there is no same-cycle turnaround from DONE to an accept.
REQ-020 SHALL drive out_data with the previous result (bytes not yet converted keep their old value) while in BUSY; out_data is qualified only by out_valid.
REQ-021 SHALL keep out_valid high with unchanged data for any number of cycles while out_ready is low.

Reset
REQ-022 SHALL, when rst is high at a rising edge, force IDLE, counter=0, out_valid=0, busy=0, out_data=128'h0, in_ready=1 on the next cycle.
REQ-023 SHALL let rst override any simultaneous accept or output handshake; a state in flight is discarded with no out_valid pulse.
REQ-024 SHALL require no reset cycles beyond one for correct operation.

Configuration
REQ-025 SHALL use macro INV_SUB_BYTES_PAR4_EN to select throughput.
REQ-026 SHALL, with INV_SUB_BYTES_PAR4_EN defined, instantiate four inverse S-box lookups and convert bytes 4k..4k+3 per BUSY cycle (4 BUSY cycles).
REQ-027 SHALL, without INV_SUB_BYTES_PAR4_EN, instantiate one inverse S-box lookup and convert one byte per BUSY cycle (16 BUSY cycles).
REQ-028 SHALL leave ports, FSM states, handshake rules and results identical between the two modes; only latency differs.

Verification
REQ-029 SHALL cover: in_data=637c777bf26b6fc53001672bfed7ab76 -> out_data=000102030405060708090a0b0c0d0e0f, with out_valid 16 edges after the accept (4 in PAR4).
REQ-030 SHALL cover: in_data all 8'h16 -> all 8'hff; in_data all 8'h00 -> all 8'h52; in_data all 8'h52 -> all 8'h48.
REQ-031 SHALL cover: out_ready held low 10 cycles in DONE -> out_valid stays 1, out_data is unchanged, in_ready=0, and a second in_valid is ignored.
REQ-032 SHALL cover: rst pulsed at BUSY cycle 7 -> next cycle IDLE, out_data=0, out_valid=0, in_ready=1; no out_valid for the aborted state.
REQ-033 SHALL cover: back-to-back states with in_valid and out_ready held high -> each result is correct, with exactly one idle in_ready cycle between jobs (throughput one state per 18 cycles by default, 6 in PAR4).
REQ-034 SHALL cover: an exhaustive sweep of all 256 byte values in byte position 0 (others 0x63) -> InvSbox(Sbox(x)) = x for every x.

Source files
------------

// File: rtl/inv_sub_bytes.sv
// inv_sub_bytes: AES InvSubBytes over one 128-bit state.
//   The state is captured on an accept and converted N bytes per cycle,
//   in ascending byte order (byte 0 first), through inverse S-box lookups.
//   Define INV_SUB_BYTES_PAR4_EN for four lookups per cycle (4 BUSY cycles).
//   Leave it undefined for one lookup per cycle (16 BUSY cycles).
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   upstream presents a state on in_data
//   in_ready   high only in IDLE
//   in_data    byte 0 = [127:120], byte 15 = [7:0]
//   out_valid  high only in DONE; qualifies out_data
//   out_ready  downstream accepts out_data
//   out_data   InvSubBytes result, same byte order as in_data
//   busy       high only in BUSY
module inv_sub_bytes (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

`ifdef INV_SUB_BYTES_PAR4_EN
    localparam int unsigned N = 4;
`else
    localparam int unsigned N = 1;
`endif

    localparam logic [3:0] CNT_STEP = 4'(N);
    localparam logic [3:0] CNT_LAST = 4'(16 - N);

    // Inverse S-box; entry 0 is the leftmost byte of the first row.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [3:0]       cnt;
    logic [0:15][7:0] src_q;
    logic [0:15][7:0] res_q;
    logic [3:0]       lut_idx [N];
    logic [7:0]       lut_out [N];

    // Lookup k handles byte cnt+k; cnt is always a multiple of N, so no wrap.
    for (genvar g = 0; g < N; g++) begin : g_lut
        assign lut_idx[g] = cnt + 4'(g);
        assign lut_out[g] = INV_SBOX[src_q[lut_idx[g]]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result bytes are overwritten in place, so unconverted positions still
    // show the previous result while BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            src_q <= '0;
            res_q <= '0;
        end else if (accept) begin
            cnt   <= '0;
            src_q <= in_data;
        end else if (state == BUSY) begin
            cnt <= cnt + CNT_STEP;
            for (int unsigned k = 0; k < N; k++) begin
                res_q[lut_idx[k]] <= lut_out[k];
            end
        end
    end

    assign out_data = res_q;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// tb_inv_sub_bytes: directed bench for inv_sub_bytes.
//   Table of known vectors, output hold, mid-job reset, back-to-back jobs and
//   a 256-value sweep using an independent forward S-box.
//   Honours INV_SUB_BYTES_PAR4_EN for the expected latency.
module tb_inv_sub_bytes;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;

    always #5 clk = ~clk;

`ifdef INV_SUB_BYTES_PAR4_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 16;
`endif
    localparam int NB     = 16 / LAT;
    localparam int RST_AT = (LAT > 7) ? 7 : LAT - 1;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef struct {
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [5];
    int   n_checks = 0;
    int   n_fail   = 0;

    inv_sub_bytes dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic check_data(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Presents d while IDLE; returns at the negedge right after the accept edge.
    task automatic start_job(input logic [127:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        check_int("in_ready_before_accept", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        check_int("busy_after_accept", int'(busy), 1);
        check_int("in_ready_in_busy", int'(in_ready), 0);
    endtask

    // Counts edges from the accept edge until out_valid is seen (bounded).
    task automatic wait_done(output int edges);
        edges = 0;
        while (!out_valid && edges < 64) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_int("in_ready_after_handshake", int'(in_ready), 1);
        check_int("out_valid_after_handshake", int'(out_valid), 0);
    endtask

    task automatic run_job(input logic [127:0] d, input logic [127:0] e);
        int edges;
        start_job(d);
        wait_done(edges);
        check_int("latency", edges, LAT);
        check_int("out_valid_done", int'(out_valid), 1);
        check_data("out_data", out_data, e);
        release_out();
    endtask

    initial begin
        int               edges;
        int               job;
        int               cyc;
        int               last;
        int               idle_cnt;
        int               vcnt;
        logic [0:15][7:0] pe;
        logic [0:15][7:0] ne;
        logic [7:0]       sb;

        vecs[0] = '{128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f};
        vecs[1] = '{{16{8'h16}}, {16{8'hff}}};
        vecs[2] = '{{16{8'h00}}, {16{8'h52}}};
        vecs[3] = '{{16{8'h52}}, {16{8'h48}}};
        vecs[4] = '{128'h76abd7fe2b670130c56f6bf27b777c63, 128'h0f0e0d0c0b0a09080706050403020100};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_int("reset_in_ready", int'(in_ready), 1);
        check_int("reset_out_valid", int'(out_valid), 0);
        check_int("reset_busy", int'(busy), 0);
        check_data("reset_out_data", out_data, '0);

        // Known vectors
        for (int i = 0; i < 5; i++) begin
            run_job(vecs[i].din, vecs[i].exp);
        end

        // Output held while out_ready is low; new input ignored
        start_job(vecs[2].din);
        wait_done(edges);
        check_int("hold_latency", edges, LAT);
        in_valid = 1'b1;
        in_data  = vecs[1].din;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_int("hold_out_valid", int'(out_valid), 1);
            check_data("hold_out_data", out_data, vecs[2].exp);
            check_int("hold_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        release_out();
        @(negedge clk);
        check_int("hold_no_accept_busy", int'(busy), 0);
        check_int("hold_no_accept_in_ready", int'(in_ready), 1);

        // Partial conversion, then reset in the middle of BUSY
        start_job(vecs[0].din);
        @(negedge clk);
        pe = vecs[2].exp;
        ne = vecs[0].exp;
        for (int i = 0; i < NB; i++) begin
            pe[i] = ne[i];
        end
        check_data("partial_out_data", out_data, pe);
        for (int i = 1; i < RST_AT; i++) begin
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_int("abort_in_ready", int'(in_ready), 1);
        check_int("abort_out_valid", int'(out_valid), 0);
        check_int("abort_busy", int'(busy), 0);
        check_data("abort_out_data", out_data, '0);
        vcnt = 0;
        for (int i = 0; i < 2 * LAT + 4; i++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        check_int("abort_no_out_valid", vcnt, 0);

        // Back-to-back jobs with in_valid and out_ready held high
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = vecs[0].din;
        job       = 0;
        cyc       = 0;
        last      = 0;
        idle_cnt  = 0;
        while (job < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (in_ready) idle_cnt++;
            if (out_valid) begin
                check_data("b2b_out_data", out_data, vecs[job].exp);
                if (job > 0) begin
                    check_int("b2b_period", cyc - last, LAT + 2);
                    check_int("b2b_idle_cycles", idle_cnt, 1);
                end
                last     = cyc;
                idle_cnt = 0;
                job++;
                in_data  = vecs[job].din;
                if (job == 3) in_valid = 1'b0;
            end
        end
        check_int("b2b_jobs", job, 3);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);

        // Sweep byte 0 through every value
        for (int x = 0; x < 256; x++) begin
            sb = SBOX[x];
            run_job({sb, {15{8'h63}}}, {8'(x), 120'h0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
